// File: rtl/debug_capture_ila.sv
// Integrated logic analyzer: samples a wide probe bus into a circular
// buffer, triggers on a masked value match and keeps a programmable
// number of pre-trigger samples. The buffer is read back through a
// registered port indexed from the oldest sample of the capture.
//
// Optional build macro: ILA_STORAGE_QUALIFIER_EN
//   When defined, qual gates every store and every counter step, and a
//   trigger is only accepted on a qualified (stored) cycle.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no capture running, buffer holds the previous capture
// PRETRIG   | filling the first P samples, trigger hits ignored
// WAIT_TRIG | storing continuously, waiting for a trigger hit
// POSTTRIG  | storing the DEPTH-P-1 samples that follow the trigger
// DONE      | capture complete, buffer valid, no writes

module debug_capture_ila #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] probe,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [ADDR_W-1:0] pretrig,
    input  logic              arm,
    input  logic              abort,
    input  logic              qual,
    output logic              armed,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRETRIG,
        ST_WAIT_TRIG,
        ST_POSTTRIG,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [ADDR_W-1:0] p_eff;
    logic [ADDR_W-1:0] post_len;
    logic [ADDR_W-1:0] rd_ptr;
    logic              hit;
    logic              qual_ok;
    logic              cap;
    logic              trig_fire;
    logic              done_set;

`ifdef ILA_STORAGE_QUALIFIER_EN
    assign qual_ok = qual;
`else
    logic unused_qual;
    assign unused_qual = qual;
    assign qual_ok     = 1'b1;
`endif

    // pretrig is ADDR_W bits wide, so it can never exceed DEPTH-1; the
    // clamp to DEPTH-1 is therefore the identity here.
    assign p_eff    = pretrig;
    // DEPTH-P-1 in ADDR_W-bit arithmetic is the bitwise complement of P.
    assign post_len = ~p_eff;
    assign hit      = (((probe ^ trig_value) & trig_mask) == '0);
    assign armed    = (state == ST_PRETRIG) || (state == ST_WAIT_TRIG) ||
                      (state == ST_POSTTRIG);
    // Logical index 0 is the oldest sample: P samples before the trigger.
    assign rd_ptr   = trig_addr - p_eff + rd_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state, store enable and counter update; abort beats arm.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap       = 1'b0;
        trig_fire = 1'b0;
        done_set  = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else if (arm) begin
            cnt_nxt   = '0;
            state_nxt = (p_eff == '0) ? ST_WAIT_TRIG : ST_PRETRIG;
        end else begin
            case (state)
                ST_PRETRIG: begin
                    if (qual_ok) begin
                        cap     = 1'b1;
                        cnt_nxt = cnt + ADDR_W'(1);
                        if (cnt_nxt == p_eff) state_nxt = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (qual_ok) begin
                        cap = 1'b1;
                        if (hit) begin
                            trig_fire = 1'b1;
                            cnt_nxt   = post_len;
                            if (post_len == '0) begin
                                done_set  = 1'b1;
                                state_nxt = ST_DONE;
                            end else begin
                                state_nxt = ST_POSTTRIG;
                            end
                        end
                    end
                end
                ST_POSTTRIG: begin
                    if (qual_ok) begin
                        cap     = 1'b1;
                        cnt_nxt = cnt - ADDR_W'(1);
                        if (cnt == ADDR_W'(1)) begin
                            done_set  = 1'b1;
                            state_nxt = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Write pointer, counter, trigger bookkeeping and status flags.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            wptr      <= '0;
            cnt       <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
            trig_addr <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (!abort && arm) begin
                wptr      <= '0;
                triggered <= 1'b0;
                done      <= 1'b0;
            end else begin
                if (cap) wptr <= wptr + ADDR_W'(1);
                if (trig_fire) begin
                    trig_addr <= wptr;
                    triggered <= 1'b1;
                end
                if (done_set) done <= 1'b1;
            end
        end
    end

    // Sample RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (cap) mem[wptr] <= probe;
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset_i) rd_data <= '0;
        else         rd_data <= mem[rd_ptr];
    end

endmodule

// File: tb/tb_debug_capture_ila.sv
// Self-checking bench for debug_capture_ila. A sample-list reference
// model predicts status outputs each cycle and the captured window.
module tb_debug_capture_ila;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic [DATA_W-1:0] probe = '0;
    logic [DATA_W-1:0] trig_mask = '0;
    logic [DATA_W-1:0] trig_value = '0;
    logic [ADDR_W-1:0] pretrig = '0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              qual = 1'b0;
    logic              armed;
    logic              triggered;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;

    always #5 clk = ~clk;

    debug_capture_ila #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_i   (reset_i),
        .probe     (probe),
        .trig_mask (trig_mask),
        .trig_value(trig_value),
        .pretrig   (pretrig),
        .arm       (arm),
        .abort     (abort),
        .qual      (qual),
        .armed     (armed),
        .triggered (triggered),
        .done      (done),
        .trig_addr (trig_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: list of stored samples since arm, trigger index
    logic              m_active = 1'b0;
    logic              m_trig   = 1'b0;
    logic              m_done   = 1'b0;
    int                m_taddr  = 0;
    int                m_p      = 0;
    int                m_n      = 0;
    int                m_tidx   = -1;
    logic [DATA_W-1:0] samp[$];

    int probe_mode = 0;  // 0: counter since arm, 1: random
    int qual_mode  = 0;  // 0: always 1, 1: toggle, 2: random
    int ctr        = 0;

    task automatic model_step();
        logic q_ok;
        logic m_hit;
        if (reset_i) begin
            m_active = 1'b0; m_trig = 1'b0; m_done = 1'b0; m_taddr = 0;
            return;
        end
        if (abort) begin
            m_active = 1'b0;
            return;
        end
        if (arm) begin
            m_active = 1'b1; m_trig = 1'b0; m_done = 1'b0;
            m_n = 0; m_tidx = -1; m_p = int'(pretrig);
            samp.delete();
            return;
        end
        if (!m_active) return;
`ifdef ILA_STORAGE_QUALIFIER_EN
        q_ok = qual;
`else
        q_ok = 1'b1;
`endif
        if (!q_ok) return;
        m_hit = (((probe ^ trig_value) & trig_mask) == '0);
        samp.push_back(probe);
        if (m_tidx < 0 && m_n >= m_p && m_hit) begin
            m_tidx  = m_n;
            m_trig  = 1'b1;
            m_taddr = m_n % DEPTH;
        end
        if (m_tidx >= 0 && m_n == m_tidx + DEPTH - 1 - m_p) begin
            m_done   = 1'b1;
            m_active = 1'b0;
        end
        m_n++;
    endtask

    task automatic tick();
        if (probe_mode == 0) probe = DATA_W'(ctr);
        else probe = {$urandom, $urandom, $urandom, $urandom};
        case (qual_mode)
            0:       qual = 1'b1;
            1:       qual = ~qual;
            default: qual = 1'($urandom_range(0, 1));
        endcase
        model_step();
        @(posedge clk);
        #1;
        ctr++;
        check_val("armed", DATA_W'(armed), DATA_W'(m_active));
        check_val("triggered", DATA_W'(triggered), DATA_W'(m_trig));
        check_val("done", DATA_W'(done), DATA_W'(m_done));
        check_val("trig_addr", DATA_W'(trig_addr), DATA_W'(m_taddr));
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        ctr = 0;
    endtask

    task automatic run_to_done(input int budget);
        for (int k = 0; k < budget && !m_done; k++) tick();
        check_val("done_in_budget", DATA_W'(done), DATA_W'(1));
    endtask

    task automatic rd_one(input int idx, output logic [DATA_W-1:0] val);
        rd_addr = ADDR_W'(idx);
        tick();
        val = rd_data;
    endtask

    task automatic read_all(input string tag);
        logic [DATA_W-1:0] v;
        if (m_tidx < 0) return;
        for (int i = 0; i < DEPTH; i++) begin
            rd_one(i, v);
            check_val(tag, v, samp[m_tidx - m_p + i]);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        int lat;

        // reset
        reset_i = 1'b1;
        repeat (3) tick();
        check_val("rst_rd_data", rd_data, '0);
        reset_i = 1'b0;
        tick();

        // T1: pretrig 0, mask 0 -> immediate trigger, done 1024 cycles after arm
        trig_mask = '0; trig_value = '0; pretrig = '0;
        do_arm();
        lat = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick();
            if (done) begin lat = k; break; end
        end
        check_val("t1_done_latency", DATA_W'(lat), DATA_W'(1024));
        check_val("t1_trig_addr", DATA_W'(trig_addr), DATA_W'(0));
        read_all("t1_rd");

        // T2: counter probe, match 500, pretrig 100
        trig_mask = '1; trig_value = DATA_W'(500); pretrig = 10'd100;
        do_arm();
        run_to_done(3000);
        check_val("t2_trig_addr", DATA_W'(trig_addr), DATA_W'(500));
        rd_one(100, v);  check_val("t2_rd100", v, DATA_W'(500));
        rd_one(0, v);    check_val("t2_rd0", v, DATA_W'(400));
        rd_one(1023, v); check_val("t2_rd1023", v, DATA_W'(1423));
        read_all("t2_rd");

        // T3: match value inside the pre-trigger window is ignored
        trig_mask = DATA_W'(10'h3FF); trig_value = DATA_W'(50); pretrig = 10'd100;
        do_arm();
        repeat (600) tick();
        check_val("t3_no_early_trig", DATA_W'(triggered), DATA_W'(0));
        check_val("t3_still_armed", DATA_W'(armed), DATA_W'(1));
        run_to_done(3000);
        check_val("t3_trig_addr", DATA_W'(trig_addr), DATA_W'(50));
        read_all("t3_rd");

        // T4: pretrig 1023 -> done on the trigger cycle itself
        trig_mask = '0; trig_value = '0; pretrig = 10'd1023;
        do_arm();
        run_to_done(2000);
        check_val("t4_trig_with_done", DATA_W'(triggered), DATA_W'(1));
        rd_one(1023, v); check_val("t4_rd1023", v, DATA_W'(1023));
        read_all("t4_rd");

        // T5: abort during POSTTRIG, then reset together with arm
        trig_mask = '0; pretrig = 10'd10;
        do_arm();
        repeat (30) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("t5_abort_armed", DATA_W'(armed), DATA_W'(0));
        check_val("t5_abort_done", DATA_W'(done), DATA_W'(0));
        check_val("t5_abort_trig_kept", DATA_W'(triggered), DATA_W'(1));
        check_val("t5_abort_taddr_kept", DATA_W'(trig_addr), DATA_W'(10));
        repeat (5) tick();
        reset_i = 1'b1; arm = 1'b1;
        tick();
        reset_i = 1'b0; arm = 1'b0;
        check_val("t5_rst_armed", DATA_W'(armed), DATA_W'(0));
        check_val("t5_rst_trig", DATA_W'(triggered), DATA_W'(0));
        check_val("t5_rst_taddr", DATA_W'(trig_addr), DATA_W'(0));
        check_val("t5_rst_done", DATA_W'(done), DATA_W'(0));
        tick();

        // T6: qual toggling every cycle, pretrig 4
        qual_mode = 1;
        trig_mask = DATA_W'(10'h3FE); trig_value = DATA_W'(20); pretrig = 10'd4;
        do_arm();
        run_to_done(5000);
        read_all("t6_rd");
        qual_mode = 0;

        // T7: random probe, random qual, random pretrig and sparse mask
        probe_mode = 1;
        for (int r = 0; r < 6; r++) begin
            qual_mode  = 2;
            pretrig    = ADDR_W'($urandom_range(0, DEPTH - 1));
            trig_mask  = DATA_W'($urandom_range(1, 15));
            trig_value = DATA_W'($urandom_range(0, 15));
            do_arm();
            run_to_done(8000);
            read_all("t7_rd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debug_capture_ila.md
Name: debug_capture_ila

Overview:
On-chip logic-analyzer core that samples a wide probe bus on every enabled clock into a circular buffer. It triggers on a masked value match and keeps a programmable number of pre-trigger samples. Host logic reads the buffer back through a simple synchronous read port. It sits beside the USB/register interface and probes FIFO-bus signals (data, strobes, flags) for debugging.

Parameters:
DATA_W, 128, probe/sample width in bits
ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples

Ports:
clk  in  1  sample/system clock; all logic on rising edge
reset_i  in  1  synchronous, active-high reset
probe  in  DATA_W  sampled data, also used for the trigger compare
trig_mask  in  DATA_W  1 = bit participates in the trigger compare
trig_value  in  DATA_W  required value of the masked bits
pretrig  in  ADDR_W  pre-trigger sample count
arm  in  1  single-cycle pulse that starts or restarts a capture
abort  in  1  returns the core to IDLE; buffer contents kept
qual  in  1  storage qualifier, used only with the optional feature
armed  out  1  high in PRETRIG, WAIT_TRIG and POSTTRIG
triggered  out  1  high from the trigger cycle until next arm or reset
done  out  1  capture complete; buffer valid
trig_addr  out  ADDR_W  physical buffer address of the trigger sample
rd_addr  in  ADDR_W  logical read index; 0 = oldest sample of the capture
rd_data  out  DATA_W  sample at rd_addr, registered

Behaviour:
- Reset: state=IDLE; armed, triggered, done, trig_addr, rd_data, write pointer and counters = 0. Buffer RAM is not cleared.
- Reset wins over arm and abort in the same cycle. Abort wins over arm.
- States are IDLE, PRETRIG, WAIT_TRIG, POSTTRIG and DONE.
- Trigger compare (combinational, on the current probe): hit = (((probe ^ trig_value) & trig_mask) == 0). An all-zero mask gives hit every cycle.
- Capture cycle: a cycle in PRETRIG, WAIT_TRIG or POSTTRIG. It writes probe to mem[wptr] and sets wptr <= wptr+1, wrapping modulo DEPTH.
- Effective pretrig: P = min(pretrig, DEPTH-1).
- arm (in any state): wptr<=0, counters<=0, triggered<=0, done<=0. Next state is PRETRIG, or WAIT_TRIG if P==0.
- PRETRIG: stores samples and counts them. Hits are ignored. Moves to WAIT_TRIG in the cycle the P-th sample is written.
- WAIT_TRIG: stores samples continuously, overwriting the oldest. On hit, the sample is written as normal, trig_addr<=wptr and triggered<=1. The post-trigger counter is loaded with DEPTH-P-1, then the core goes to POSTTRIG, or straight to DONE if that count is 0.
- POSTTRIG: stores one sample per cycle and decrements the counter. The cycle that writes the last sample sets done<=1 and moves to DONE.
- Total stored per capture: exactly DEPTH samples, made of P pre-trigger samples, the trigger sample, and DEPTH-P-1 post-trigger samples.
- DONE / IDLE: no writes. armed=0.
- Readout, available in any state:
  - start = trig_addr - P (mod DEPTH).
  - rd_data <= mem[(start + rd_addr) mod DEPTH], one-cycle latency.
  - Reads during capture return the data present in the RAM, with no coherency guarantee.
- Abort mid-capture: go to IDLE. triggered and trig_addr keep their values; done stays 0.
- Memory: single write port and single registered read port, inferable as block RAM.

Optional Feature:
Macro ILA_STORAGE_QUALIFIER_EN.
- Defined:
  - A capture cycle additionally requires qual==1; PRETRIG and POSTTRIG counters advance only on qualified cycles.
  - A hit in WAIT_TRIG is accepted only when qual==1, so the trigger sample is always stored.
- Undefined: the qual port still exists but is ignored; every cycle in the capture states is a capture cycle.

Test Plan:
- DEPTH=1024, pretrig=0, mask=0 → arm triggers on the first cycle; trig_addr=0; done exactly 1024 cycles after arm; rd_addr 0..1023 returns probe values in write order, 1-cycle read latency.
- Probe = free-running counter, mask=all-ones, value=500, pretrig=100 → trig_addr=500; rd_addr 100 reads 500; rd_addr 0 reads 400; rd_addr 1023 reads 1423.
- Probe counter, value=50, pretrig=100 → the hit at 50 is ignored (still in PRETRIG); no trigger until the counter wraps back to the match value; armed stays 1 meanwhile.
- pretrig=1023 (and pretrig larger than DEPTH-1 via a smaller ADDR_W build) → done on the trigger cycle itself; rd_addr 1023 is the trigger sample.
- Abort during POSTTRIG, and reset asserted together with arm → state IDLE, done=0, armed=0; reset clears triggered and trig_addr to 0.
- With ILA_STORAGE_QUALIFIER_EN, qual toggling every cycle, pretrig=4 → the stored samples are only the qual-high values; a hit while qual=0 is not taken.
